// File: rtl/ram_bus_arbiter_if.sv
// Bus bundle between the two requesters (CPU sequencer, loader), the arbiter and the data RAM.
// master = requester/RAM side, slave = arbiter side.
interface ram_bus_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic              cpu_stall;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_done;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              ram_cs;
  logic              ram_oe;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ram_rdata,
    input  cpu_gnt, cpu_done, cpu_stall, ldr_gnt, ldr_done,
    input  rd_data, busy, ram_cs, ram_oe, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ram_rdata,
    output cpu_gnt, cpu_done, cpu_stall, ldr_gnt, ldr_done,
    output rd_data, busy, ram_cs, ram_oe, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-requester data RAM arbiter: IDLE -> ACCESS (strobes held ACC_CYCLES) -> DONE pulse.
// Define RAM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module ram_bus_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int ACC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  ram_bus_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(ACC_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  count, count_nx;
  logic              owner_ldr, owner_ldr_nx;
  logic              we_l, we_l_nx;
  logic [ADDR_W-1:0] addr_l, addr_l_nx;
  logic [DATA_W-1:0] wdata_l, wdata_l_nx;
  logic              pick_ldr;

  logic              cs_r, oe_r, we_r, busy_r;
  logic              cpu_gnt_r, cpu_done_r, ldr_gnt_r, ldr_done_r;
  logic [DATA_W-1:0] rd_data_r;

`ifdef RAM_ARB_RR_EN
  logic last_ldr;

  // On a tie the loader wins only if the CPU was the last owner.
  assign pick_ldr = bus.ldr_req & (~bus.cpu_req | ~last_ldr);

  // Last-owner pointer, updated when an access is launched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ldr <= 1'b1;
    end else if (state == IDLE && (bus.cpu_req || bus.ldr_req)) begin
      last_ldr <= pick_ldr;
    end
  end
`else
  assign pick_ldr = bus.ldr_req & ~bus.cpu_req;
`endif

  // State register and latched access fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= {CNT_W{1'b0}};
      owner_ldr <= 1'b0;
      we_l      <= 1'b0;
      addr_l    <= {ADDR_W{1'b0}};
      wdata_l   <= {DATA_W{1'b0}};
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      owner_ldr <= owner_ldr_nx;
      we_l      <= we_l_nx;
      addr_l    <= addr_l_nx;
      wdata_l   <= wdata_l_nx;
    end
  end

  // Next-state logic; request fields are captured only on the IDLE->ACCESS step
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    owner_ldr_nx = owner_ldr;
    we_l_nx      = we_l;
    addr_l_nx    = addr_l;
    wdata_l_nx   = wdata_l;
    case (state)
      IDLE: begin
        if (bus.cpu_req || bus.ldr_req) begin
          state_nx     = ACCESS;
          count_nx     = CNT_W'(ACC_CYCLES - 1);
          owner_ldr_nx = pick_ldr;
          we_l_nx      = pick_ldr ? bus.ldr_we    : bus.cpu_we;
          addr_l_nx    = pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
          wdata_l_nx   = pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS: begin
        if (count != {CNT_W{1'b0}}) begin
          count_nx = count - CNT_W'(1);
        end else begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs registered from the next state so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_r       <= 1'b0;
      oe_r       <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      cpu_gnt_r  <= 1'b0;
      ldr_gnt_r  <= 1'b0;
      cpu_done_r <= 1'b0;
      ldr_done_r <= 1'b0;
    end else begin
      cs_r       <= (state_nx == ACCESS);
      oe_r       <= (state_nx == ACCESS) & ~we_l_nx;
      we_r       <= (state_nx == ACCESS) & we_l_nx;
      busy_r     <= (state_nx != IDLE);
      cpu_gnt_r  <= (state_nx != IDLE) & ~owner_ldr_nx;
      ldr_gnt_r  <= (state_nx != IDLE) & owner_ldr_nx;
      cpu_done_r <= (state_nx == DONE) & ~owner_ldr_nx;
      ldr_done_r <= (state_nx == DONE) & owner_ldr_nx;
    end
  end

  // Read data captured on the last ACCESS cycle of a read; writes leave it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (state == ACCESS && count == {CNT_W{1'b0}} && !we_l) begin
      rd_data_r <= bus.ram_rdata;
    end
  end

  assign bus.ram_cs    = cs_r;
  assign bus.ram_oe    = oe_r;
  assign bus.ram_we    = we_r;
  assign bus.ram_addr  = addr_l;
  assign bus.ram_wdata = wdata_l;
  assign bus.busy      = busy_r;
  assign bus.cpu_gnt   = cpu_gnt_r;
  assign bus.ldr_gnt   = ldr_gnt_r;
  assign bus.cpu_done  = cpu_done_r;
  assign bus.ldr_done  = ldr_done_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_done_r;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Random-stimulus bench for ram_bus_arbiter; two instances (ACC_CYCLES=2 and 1) share the inputs
// and are compared each cycle against an access-schedule model.
module tb_ram_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
  logic [6:0] cpu_addr = 7'd0, ldr_addr = 7'd0;
  logic [7:0] cpu_wdata = 8'd0, ldr_wdata = 8'd0, rdata = 8'd0;

  int n_checks = 0;
  int n_fails  = 0;

  ram_bus_arbiter_if #(.ADDR_W(7), .DATA_W(8)) b0 ();
  ram_bus_arbiter_if #(.ADDR_W(7), .DATA_W(8)) b1 ();

  assign b0.cpu_req = cpu_req;   assign b1.cpu_req = cpu_req;
  assign b0.cpu_we = cpu_we;     assign b1.cpu_we = cpu_we;
  assign b0.cpu_addr = cpu_addr; assign b1.cpu_addr = cpu_addr;
  assign b0.cpu_wdata = cpu_wdata; assign b1.cpu_wdata = cpu_wdata;
  assign b0.ldr_req = ldr_req;   assign b1.ldr_req = ldr_req;
  assign b0.ldr_we = ldr_we;     assign b1.ldr_we = ldr_we;
  assign b0.ldr_addr = ldr_addr; assign b1.ldr_addr = ldr_addr;
  assign b0.ldr_wdata = ldr_wdata; assign b1.ldr_wdata = ldr_wdata;
  assign b0.ram_rdata = rdata;   assign b1.ram_rdata = rdata;

  ram_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .ACC_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  ram_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .ACC_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  always #5 clk = ~clk;

  // Model: each access is a start cycle s; strobes in s+1..s+acc, DONE at s+acc+1, next start >= s+acc+2
  int         acc_of [2] = '{2, 1};
  int         m_start[2];
  int         m_free [2];
  bit         m_ldr  [2];
  bit         m_we   [2];
  bit         m_last_ldr[2];
  logic [6:0] m_addr [2];
  logic [7:0] m_wdata[2];
  logic [7:0] m_rd   [2];
  logic [7:0] m_rdnext[2];
  bit         in_rst;
  int         cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input int c);
    for (int d = 0; d < 2; d++) begin
      m_start[d] = -100; m_free[d] = c; m_ldr[d] = 1'b0; m_we[d] = 1'b0;
      m_last_ldr[d] = 1'b1; m_addr[d] = 7'd0; m_wdata[d] = 8'd0;
      m_rd[d] = 8'd0; m_rdnext[d] = 8'd0;
    end
  endtask

  task automatic check_dut(input int d, input string nm,
                           input logic cs, input logic oe, input logic we, input logic busy,
                           input logic cg, input logic cd, input logic cst,
                           input logic lg, input logic ld,
                           input logic [6:0] ra, input logic [7:0] rw, input logic [7:0] rd);
    int  s = m_start[d];
    int  a = acc_of[d];
    bit  acc = (cyc >= s + 1) && (cyc <= s + a);
    bit  dn  = (cyc == s + a + 1);
    if (dn && !m_we[d]) m_rd[d] = m_rdnext[d];
    check_val({nm, ".ram_cs"},   {31'd0, cs},   {31'd0, acc});
    check_val({nm, ".ram_oe"},   {31'd0, oe},   {31'd0, acc & ~m_we[d]});
    check_val({nm, ".ram_we"},   {31'd0, we},   {31'd0, acc & m_we[d]});
    check_val({nm, ".busy"},     {31'd0, busy}, {31'd0, acc | dn});
    check_val({nm, ".cpu_gnt"},  {31'd0, cg},   {31'd0, (acc | dn) & ~m_ldr[d]});
    check_val({nm, ".ldr_gnt"},  {31'd0, lg},   {31'd0, (acc | dn) & m_ldr[d]});
    check_val({nm, ".cpu_done"}, {31'd0, cd},   {31'd0, dn & ~m_ldr[d]});
    check_val({nm, ".ldr_done"}, {31'd0, ld},   {31'd0, dn & m_ldr[d]});
    check_val({nm, ".cpu_stall"}, {31'd0, cst}, {31'd0, cpu_req & ~(dn & ~m_ldr[d])});
    check_val({nm, ".ram_addr"},  {25'd0, ra},  {25'd0, m_addr[d]});
    check_val({nm, ".ram_wdata"}, {24'd0, rw},  {24'd0, m_wdata[d]});
    check_val({nm, ".rd_data"},   {24'd0, rd},  {24'd0, m_rd[d]});
  endtask

  task automatic model_step(input int c);
    bit tie, take_ldr;
    for (int d = 0; d < 2; d++) begin
      if (c == m_start[d] + acc_of[d] && !m_we[d]) m_rdnext[d] = rdata;
      if (!in_rst && c >= m_free[d] && (cpu_req || ldr_req)) begin
        tie = cpu_req && ldr_req;
`ifdef RAM_ARB_RR_EN
        take_ldr = tie ? !m_last_ldr[d] : ldr_req;
`else
        take_ldr = tie ? 1'b0 : ldr_req;
`endif
        m_last_ldr[d] = take_ldr;
        m_ldr[d]   = take_ldr;
        m_we[d]    = take_ldr ? ldr_we : cpu_we;
        m_addr[d]  = take_ldr ? ldr_addr : cpu_addr;
        m_wdata[d] = take_ldr ? ldr_wdata : cpu_wdata;
        m_start[d] = c;
        m_free[d]  = c + acc_of[d] + 2;
      end
    end
  endtask

  initial begin
    int mode;
    model_reset(0);
    in_rst = 1'b1;
    for (int c = 0; c < 2400; c++) begin
      @(negedge clk);
      cyc = c;
      if (c < 3 || (c % 250) == 117 || (c % 250) == 118 || (c % 250) == 201) begin
        rst = 1'b1;
        in_rst = 1'b1;
        model_reset(c);
      end else if (in_rst) begin
        rst = 1'b0;
        in_rst = 1'b0;
        for (int d = 0; d < 2; d++) m_free[d] = c;
      end

      mode = (c / 60) % 3;
      case (mode)
        0: begin
          cpu_req = ($urandom_range(0, 9) < 4);
          ldr_req = ($urandom_range(0, 9) < 4);
        end
        1: begin
          cpu_req = 1'b1;
          ldr_req = 1'b1;
        end
        default: begin
          cpu_req = ($urandom_range(0, 9) < 2);
          ldr_req = ($urandom_range(0, 9) < 6);
        end
      endcase
      cpu_we    = 1'($urandom_range(0, 1));
      ldr_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 7'($urandom);
      ldr_addr  = 7'($urandom);
      cpu_wdata = 8'($urandom);
      ldr_wdata = 8'($urandom);
      rdata     = 8'($urandom);

      #1;
      check_dut(0, "acc2", b0.ram_cs, b0.ram_oe, b0.ram_we, b0.busy, b0.cpu_gnt, b0.cpu_done,
                b0.cpu_stall, b0.ldr_gnt, b0.ldr_done, b0.ram_addr, b0.ram_wdata, b0.rd_data);
      check_dut(1, "acc1", b1.ram_cs, b1.ram_oe, b1.ram_we, b1.busy, b1.cpu_gnt, b1.cpu_done,
                b1.cpu_stall, b1.ldr_gnt, b1.ldr_done, b1.ram_addr, b1.ram_wdata, b1.rd_data);
      model_step(c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
